// File: rtl/aes_ksa_pkg.sv
// Shared definitions for the AES key-schedule blocks: key-size codes,
// round counts and the round-key reader state encoding.
package aes_ksa_pkg;

    localparam logic [1:0] KS_AES128 = 2'b00;
    localparam logic [1:0] KS_AES192 = 2'b01;
    localparam logic [1:0] KS_AES256 = 2'b10;

    localparam logic [3:0] NR_AES128 = 4'd10;
    localparam logic [3:0] NR_AES192 = 4'd12;
    localparam logic [3:0] NR_AES256 = 4'd14;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_ISSUE = 3'd2,
        ST_CAPT  = 3'd3,
        ST_VALID = 3'd4
    } rk_state_e;

    // Unused code 11 falls back to the AES-128 round count.
    function automatic logic [3:0] nr_from_key_size(input logic [1:0] ks);
        case (ks)
            KS_AES192: return NR_AES192;
            KS_AES256: return NR_AES256;
            default:   return NR_AES128;
        endcase
    endfunction

endpackage

// File: rtl/aes_round_key_reader_rk_addr_gen.sv
// Base word address of a round key in the 64-word schedule memory.
// Decrypt walks the schedule from the last round key back to the first.
module rk_addr_gen
    import aes_ksa_pkg::*;
(
    input  logic [3:0] rk_round,
    input  logic [3:0] nr,
    input  logic       e_d,
    output logic [5:0] base_addr
);

    logic [3:0] key_idx;

    // Pick the schedule slot for this round and scale to four words per key.
    always_comb begin
        key_idx   = e_d ? rk_round : (nr - rk_round);
        base_addr = {key_idx, 2'b00};
    end

endmodule

// File: rtl/aes_round_key_reader.sv
// Fetches one 128-bit round key per request from the round-key memory,
// a 32-bit word at a time, and hands it over with valid/ready.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | schedule not ready, nothing latched
// ARMED    | waiting for rk_req for round rk_round
// ISSUE    | address on the bus, memory registers the word this edge
// CAPT     | registered word available, capture into rk_data
// VALID    | full key presented, waiting for rk_ready
//
// The memory output mux depends on the live address, so mem_addr is held
// for a full ISSUE/CAPT pair and never runs ahead of the captured word.
module aes_round_key_reader
    import aes_ksa_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              key_done,
    input  logic [1:0]        key_size,
    input  logic              E_D,
    input  logic              rk_req,
    input  logic              rk_ready,
    input  logic [31:0]       mem_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              rk_valid,
    output logic [127:0]      rk_data,
    output logic [3:0]        rk_round,
    output logic              rk_last,
    output logic              busy
);

    rk_state_e  state;
    rk_state_e  state_nxt;
    logic [3:0] nr_r;
    logic       e_d_r;
    logic [1:0] w;
    logic [5:0] base_addr;

    rk_addr_gen u_addr_gen (
        .rk_round  (rk_round),
        .nr        (nr_r),
        .e_d       (e_d_r),
        .base_addr (base_addr)
    );

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; losing key_done aborts from any active state.
    always_comb begin
        state_nxt = state;
        if (state != ST_IDLE && !key_done) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (key_done) state_nxt = ST_ARMED;
                ST_ARMED: if (rk_req)   state_nxt = ST_ISSUE;
                ST_ISSUE: state_nxt = ST_CAPT;
                ST_CAPT:  state_nxt = (w == 2'd3) ? ST_VALID : ST_ISSUE;
                ST_VALID: if (rk_ready) state_nxt = ST_ARMED;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    // Handshake and status outputs decoded from the state.
    always_comb begin
        rk_valid = (state == ST_VALID);
        busy     = (state == ST_ISSUE) || (state == ST_CAPT);
        rk_last  = (state == ST_VALID) && (rk_round == nr_r);
    end

    // Datapath: mode latch, address/word stepping, key assembly, round count.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            mem_addr <= '0;
            rk_data  <= '0;
            rk_round <= '0;
            w        <= '0;
            nr_r     <= NR_AES128;
            e_d_r    <= 1'b1;
        end else if (state != ST_IDLE && !key_done) begin
            rk_round <= '0;
            w        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (key_done) begin
                        nr_r     <= nr_from_key_size(key_size);
                        e_d_r    <= E_D;
                        rk_round <= '0;
                    end
                end
                ST_ARMED: begin
                    if (rk_req) begin
                        mem_addr <= ADDR_W'(base_addr);
                        w        <= '0;
                    end
                end
                ST_CAPT: begin
                    case (w)
                        2'd0:    rk_data[127:96] <= mem_data;
                        2'd1:    rk_data[95:64]  <= mem_data;
                        2'd2:    rk_data[63:32]  <= mem_data;
                        default: rk_data[31:0]   <= mem_data;
                    endcase
                    if (w != 2'd3) begin
                        w        <= w + 2'd1;
                        mem_addr <= mem_addr + ADDR_W'(1);
                    end
                end
                ST_VALID: begin
                    if (rk_ready) begin
                        rk_round <= (rk_round == nr_r) ? 4'd0 : rk_round + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/aes_round_key_reader.md
# aes_round_key_reader

Read-side companion to the key-schedule block. Once the schedule has been written to the 32x64 round-key memory, this block fetches the 128-bit round key for the next cipher round, one 32-bit word at a time, through the memory's top-side address port. It presents each key to the round datapath with a valid/ready handshake. It orders rounds forward for encryption and backward for decryption, and owns the address timing that the memory's registered output and address-dependent inverse-MixColumns output mux require.

## Interface
Parameters:
- `ADDR_W`, default 6: round-key memory address width (64 words).

Ports:
- `CLK` in 1: single clock, rising edge.
- `RST` in 1: asynchronous, active-low reset.
- `key_done` in 1: schedule complete. The memory is readable only while this is high.
- `key_size` in 2: key length code. 00 = AES-128 (Nr = 10), 01 = AES-192 (Nr = 12), 10 = AES-256 (Nr = 14), 11 = treated as AES-128.
- `E_D` in 1: 1 = encrypt order, 0 = decrypt order.
- `rk_req` in 1: request the key for round `rk_round`. Sampled only in ARMED.
- `rk_ready` in 1: the consumer accepts `rk_data`.
- `mem_data` in 32: memory data output (post inverse-mix select).
- `mem_addr` out ADDR_W: drives the memory's top-side address.
- `rk_valid` out 1: `rk_data` holds a complete round key.
- `rk_data` out 128: round key; word 0 is in bits [127:96].
- `rk_round` out 4: index (0..Nr) of the round being served.
- `rk_last` out 1: high with `rk_valid` when `rk_round == Nr`.
- `busy` out 1: a fetch is in progress (ISSUE or CAPT).

## Operation
- States:
  - IDLE
  - ARMED
  - ISSUE
  - CAPT
  - VALID
- Transitions:
  - IDLE → ARMED when `key_done` = 1. On this transition, latch `key_size` and `E_D` and set `rk_round` = 0.
  - ARMED → ISSUE on `rk_req` = 1. Load `mem_addr` = base + 0 and clear the word counter `w`.
  - ISSUE → CAPT unconditionally. The memory registers the word on this edge.
  - CAPT → ISSUE when `w` < 3. Shift `mem_data` into `rk_data[127-32w -: 32]`, increment `w` and `mem_addr`.
  - CAPT → VALID when `w` = 3. Capture the last word and assert `rk_valid`.
  - VALID → ARMED on `rk_ready` = 1. Set `rk_round` to `rk_round` + 1, or to 0 if `rk_round` was Nr.
- Base address:
  - Encrypt: base = 4·`rk_round`.
  - Decrypt: base = 4·(Nr − `rk_round`).
  - Computed in 6 bits; the maximum address is 59 (AES-256).
- `mem_addr` is held constant through ISSUE and CAPT of a word. The memory's output-mux select depends on the current address, so addresses are never pipelined.
- `rk_data` is stable while `rk_valid` = 1 and is not zeroed between rounds.
- `key_done` falling in any state other than IDLE sends the block to IDLE on the next edge. This clears `rk_valid`, `busy` and `rk_round`, and any partial key is discarded.
- `rk_req` outside ARMED is ignored. `rk_ready` outside VALID is ignored.
- A new `key_size` or `E_D` takes effect only after passing through IDLE.

## Timing
- Reset values:
  - `mem_addr` = 0
  - `rk_data` = 0
  - `rk_valid` = 0
  - `rk_last` = 0
  - `rk_round` = 0
  - `busy` = 0
  - state = IDLE
- Fetch latency: `rk_req` is accepted on edge E0. `mem_addr` steps at E2, E4 and E6. `rk_valid` rises after E8, i.e. 8 cycles per round key.
- Back-to-back operation: `rk_ready` and `rk_req` both held high give one key every 10 cycles (8 fetch + VALID + ARMED).
- Full schedule, counting the 10-cycle repeat period per round: AES-128 takes 11 keys (110 cycles); AES-256 takes 15 keys (150 cycles).

## Structure
- Shared package `aes_ksa_pkg` holds:
  - the key-size codes;
  - the Nr constants 10, 12 and 14;
  - the state enum.
- One natural sub-module is `rk_addr_gen`: a combinational base-address calculation from `rk_round`, Nr and `E_D`.

## Test plan
- AES-128 encrypt, memory preloaded from key 2b7e151628aed2a6abf7158809cf4f3c:
  - round 0 `rk_data` = 2b7e151628aed2a6abf7158809cf4f3c;
  - round 10 `rk_data` = d014f9a8c9ee2589e13f0cc8b6630ca6 with `rk_last` = 1;
  - `mem_addr` walks 0..43.
- AES-128 decrypt, same key:
  - round 0 reads addresses 40..43 and returns d014f9a8c9ee2589e13f0cc8b6630ca6;
  - round 10 reads 0..3 and returns 2b7e1516…;
  - `rk_round` wraps to 0 after round 10.
- AES-256 encrypt: 15 transactions; round 14 reads 56..59 with `rk_last` = 1. Then `key_size` = 11 after IDLE gives Nr = 10.
- Backpressure: hold `rk_ready` = 0 for 20 cycles in VALID. `rk_valid`, `rk_data` and `mem_addr` stay constant, and the acceptance edge advances `rk_round` by 1.
- Abort: drop `key_done` during CAPT of word 2. Next edge is IDLE with `rk_valid` = 0. On re-raise, round 0 is refetched from address 0.
- Async reset asserted during VALID: all outputs go to reset values immediately, without waiting for `CLK`. After release with `key_done` = 1, ARMED follows on the next edge.
